// File: rtl/mux4_rr_arbiter_if.sv
// Bus between the four requesters and the round-robin 4:1 mux arbiter.
// master: requester side (drives req and data). slave: arbiter side.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] i;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       valid;
  logic       y;

  modport master (output req, i, input gnt, s, valid, y);
  modport slave  (input req, i, output gnt, s, valid, y);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 4:1 one-bit mux.
// One owner at a time holds the mux; its data bit is routed to y.
// Optional macro MUX_ARB_TIMEOUT_EN: pre-empt an owner after HOLD_MAX
// consecutive grant cycles when another request is pending.
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux4_rr_arbiter_if.slave bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold_max
    $error("HOLD_MAX must be in 1..15");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [3:0] gnt_q;
  logic [1:0] s_q;
  logic       valid_q;
`ifdef MUX_ARB_TIMEOUT_EN
  logic [3:0] cnt_q;
`endif

  // First requester found scanning start, start+1, ... modulo 4; {found, index}.
  function automatic logic [2:0] rr_search(input logic [1:0] start, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [3:0] others;
  logic [2:0] idle_win;
  logic [2:0] rot_win;
  logic       release_own;
  logic       rotate;

  // Winner candidates: from ptr when idle, from owner+1 (owner excluded) on rotation.
  always_comb begin
    others      = bus.req & ~gnt_q;
    idle_win    = rr_search(ptr_q, bus.req);
    rot_win     = rr_search(s_q + 2'd1, others);
    release_own = ~bus.req[s_q];
`ifdef MUX_ARB_TIMEOUT_EN
    rotate      = release_own || ((cnt_q == 4'(HOLD_MAX)) && (|others));
`else
    rotate      = release_own;
`endif
  end

  // Arbitration FSM with registered grant, select and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      s_q     <= 2'b00;
      valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (idle_win[2]) begin
            gnt_q   <= 4'b0001 << idle_win[1:0];
            s_q     <= idle_win[1:0];
            valid_q <= 1'b1;
            state_q <= StGrant;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q   <= 4'd1;
`endif
          end
        end
        StGrant: begin
          if (rotate) begin
            ptr_q <= s_q + 2'd1;
            if (rot_win[2]) begin
              // Hand over in the same edge: no idle bubble between owners.
              gnt_q <= 4'b0001 << rot_win[1:0];
              s_q   <= rot_win[1:0];
`ifdef MUX_ARB_TIMEOUT_EN
              cnt_q <= 4'd1;
`endif
            end else begin
              // s keeps its last value while idle.
              gnt_q   <= 4'b0000;
              valid_q <= 1'b0;
              state_q <= StIdle;
`ifdef MUX_ARB_TIMEOUT_EN
              cnt_q   <= 4'd0;
`endif
            end
          end else begin
`ifdef MUX_ARB_TIMEOUT_EN
            if (cnt_q != 4'd15) cnt_q <= cnt_q + 4'd1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Registered outputs and the combinational data route.
  assign bus.gnt   = gnt_q;
  assign bus.s     = s_q;
  assign bus.valid = valid_q;
  assign bus.y     = valid_q & bus.i[s_q];

endmodule
